// File: rtl/fm_sb_pkg.sv
// Shared types and defaults for the spybuffer readback arbiter.
// Holds the FSM state encoding and the default sizing of the readback path.
package fm_sb_pkg;

  localparam int sb_mapped_n = 27;
  localparam int axi_dw      = 32;
  localparam int tmo_default = 255;
  localparam int wait_cnt_w  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/fm_rr_pick.sv
// Combinational round-robin finder: first set bit of req at or above ptr,
// wrapping from N-1 back to 0.
module fm_rr_pick #(
  parameter int N  = 27,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] idx,
  output logic          found
);

  always_comb begin
    int k;
    k     = 0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!found && (k < N) && req[k[SW-1:0]]) begin
        found = 1'b1;
        idx   = k[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/fm_sb_rd_arb.sv
// Arbiter for the shared spybuffer readback port: round-robin grant, one read
// strobe per grant, response with data or timeout error.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no transaction; pick a requester when any req bit is set
//   ST_ISSUE | grant/select/address registered, sb_rd_en high this cycle
//   ST_WAIT  | waiting for sb_rd_vld, wait counter running toward TMO
//   ST_RESP  | rsp_vld high this cycle; grant released, rr_ptr advanced
module fm_sb_rd_arb
  import fm_sb_pkg::*;
#(
  parameter int N_SB   = sb_mapped_n,
  parameter int AXI_DW = axi_dw,
  parameter int ADDR_W = 12,
  parameter int TMO    = tmo_default
) (
  input  logic                     spy_clock,
  input  logic                     spy_rst_n,
  input  logic [N_SB-1:0]          req,
  input  logic [N_SB*ADDR_W-1:0]   req_addr,
  output logic [N_SB-1:0]          gnt,
  output logic                     sb_rd_en,
  output logic [$clog2(N_SB)-1:0]  sb_sel,
  output logic [ADDR_W-1:0]        sb_rd_addr,
  input  logic [AXI_DW-1:0]        sb_rd_data,
  input  logic                     sb_rd_vld,
  output logic [AXI_DW-1:0]        rsp_data,
  output logic                     rsp_vld,
  output logic                     rsp_err,
  output logic                     busy
);

  localparam int SW = $clog2(N_SB);
  localparam logic [wait_cnt_w-1:0] TMO_C    = wait_cnt_w'(TMO);
  localparam logic [SW-1:0]         LAST_IDX = SW'(N_SB - 1);
  localparam logic [N_SB-1:0]       ONE_HOT0 = {{(N_SB-1){1'b0}}, 1'b1};

  rd_state_t state, state_nxt;

  logic [SW-1:0]         rr_ptr, rr_ptr_nxt;
  logic [SW-1:0]         pick_idx;
  logic                  pick_found;
  logic [wait_cnt_w-1:0] wait_cnt, wait_cnt_nxt;
  logic                  wait_hit;

  logic [N_SB-1:0]   gnt_nxt;
  logic              sb_rd_en_nxt;
  logic [SW-1:0]     sb_sel_nxt;
  logic [ADDR_W-1:0] sb_rd_addr_nxt;
  logic [AXI_DW-1:0] rsp_data_nxt;
  logic              rsp_vld_nxt;
  logic              rsp_err_nxt;
  logic              busy_nxt;

  logic [ADDR_W-1:0] addr_arr [N_SB];

  for (genvar g = 0; g < N_SB; g++) begin : g_addr
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
  end

  fm_rr_pick #(
    .N  (N_SB),
    .SW (SW)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Counter value after this WAIT cycle; equal to TMO means the budget is spent.
  assign wait_hit = ((wait_cnt + wait_cnt_w'(1)) == TMO_C);

  always_comb begin
    state_nxt      = state;
    rr_ptr_nxt     = rr_ptr;
    wait_cnt_nxt   = wait_cnt;
    gnt_nxt        = gnt;
    sb_rd_en_nxt   = 1'b0;
    sb_sel_nxt     = sb_sel;
    sb_rd_addr_nxt = sb_rd_addr;
    rsp_data_nxt   = rsp_data;
    rsp_vld_nxt    = 1'b0;
    rsp_err_nxt    = rsp_err;

    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_nxt      = ST_ISSUE;
          gnt_nxt        = ONE_HOT0 << pick_idx;
          sb_sel_nxt     = pick_idx;
          sb_rd_addr_nxt = addr_arr[pick_idx];
          sb_rd_en_nxt   = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_nxt    = ST_WAIT;
        wait_cnt_nxt = '0;
      end
      ST_WAIT: begin
        // A valid read wins over a timeout landing in the same cycle.
        if (sb_rd_vld) begin
          state_nxt    = ST_RESP;
          rsp_data_nxt = sb_rd_data;
          rsp_err_nxt  = 1'b0;
          rsp_vld_nxt  = 1'b1;
        end else if (wait_hit) begin
          state_nxt    = ST_RESP;
          rsp_data_nxt = '0;
          rsp_err_nxt  = 1'b1;
          rsp_vld_nxt  = 1'b1;
        end else if (wait_cnt != '1) begin
          wait_cnt_nxt = wait_cnt + wait_cnt_w'(1);
        end
      end
      ST_RESP: begin
        state_nxt  = ST_IDLE;
        gnt_nxt    = '0;
        rr_ptr_nxt = (sb_sel == LAST_IDX) ? '0 : sb_sel + SW'(1);
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge spy_clock or negedge spy_rst_n) begin
    if (!spy_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge spy_clock or negedge spy_rst_n) begin
    if (!spy_rst_n) begin
      rr_ptr     <= '0;
      wait_cnt   <= '0;
      gnt        <= '0;
      sb_rd_en   <= 1'b0;
      sb_sel     <= '0;
      sb_rd_addr <= '0;
      rsp_data   <= '0;
      rsp_vld    <= 1'b0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rr_ptr     <= rr_ptr_nxt;
      wait_cnt   <= wait_cnt_nxt;
      gnt        <= gnt_nxt;
      sb_rd_en   <= sb_rd_en_nxt;
      sb_sel     <= sb_sel_nxt;
      sb_rd_addr <= sb_rd_addr_nxt;
      rsp_data   <= rsp_data_nxt;
      rsp_vld    <= rsp_vld_nxt;
      rsp_err    <= rsp_err_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_fm_sb_rd_arb.sv
// Scoreboard bench for fm_sb_rd_arb: a responder answers read strobes after a
// programmable delay, a monitor logs strobes and responses for the tests.
module tb_fm_sb_rd_arb;

  localparam int N  = 27;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int SW = 5;
  localparam logic [N-1:0] ONE = 1;

  logic            spy_clock = 1'b0;
  logic            spy_rst_n = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    gnt;
  logic            sb_rd_en;
  logic [SW-1:0]   sb_sel;
  logic [AW-1:0]   sb_rd_addr;
  logic [DW-1:0]   sb_rd_data = '0;
  logic            sb_rd_vld = 1'b0;
  logic [DW-1:0]   rsp_data;
  logic            rsp_vld;
  logic            rsp_err;
  logic            busy;

  typedef struct {logic [N-1:0] gnt; logic [SW-1:0] sel; logic [AW-1:0] addr; int cyc;} iss_t;
  typedef struct {logic err; logic [DW-1:0] data; int cyc;} rsp_t;
  typedef struct {logic [SW-1:0] sel; logic [AW-1:0] addr; logic [DW-1:0] data; logic err;} exp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  exp_t exp_q[$];
  exp_t e;
  iss_t it;
  rsp_t rt;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int resp_delay = 0;
  int resp_cnt = 0;
  bit fixed_en = 1'b0;
  logic [DW-1:0] fixed_word = '0;
  logic [DW-1:0] cap_word = '0;
  logic [76:0] got, want;
  logic [79:0] rv;

  fm_sb_rd_arb #(
    .N_SB   (N),
    .AXI_DW (DW),
    .ADDR_W (AW),
    .TMO    (4)
  ) dut (
    .spy_clock  (spy_clock),
    .spy_rst_n  (spy_rst_n),
    .req        (req),
    .req_addr   (req_addr),
    .gnt        (gnt),
    .sb_rd_en   (sb_rd_en),
    .sb_sel     (sb_sel),
    .sb_rd_addr (sb_rd_addr),
    .sb_rd_data (sb_rd_data),
    .sb_rd_vld  (sb_rd_vld),
    .rsp_data   (rsp_data),
    .rsp_vld    (rsp_vld),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 spy_clock = ~spy_clock;

  function automatic logic [DW-1:0] pat(input logic [SW-1:0] s, input logic [AW-1:0] a);
    return {8'hC3, 7'h00, s, a};
  endfunction

  function automatic logic [AW-1:0] addr_of(input int i);
    return AW'(32'h100 + i * 7);
  endfunction

  always @(negedge spy_clock) begin
    cyc++;
    if (sb_rd_en) iss_q.push_back('{gnt, sb_sel, sb_rd_addr, cyc});
    if (rsp_vld)  rsp_q.push_back('{rsp_err, rsp_data, cyc});
  end

  // Read-data responder: vld arrives resp_delay cycles after the strobe is seen.
  always @(negedge spy_clock) begin
    sb_rd_vld = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        sb_rd_vld  = 1'b1;
        sb_rd_data = cap_word;
      end
    end
    if (sb_rd_en && resp_delay > 0) begin
      resp_cnt = resp_delay;
      cap_word = fixed_en ? fixed_word : pat(sb_sel, sb_rd_addr);
    end
  end

  task automatic wait_for(input int ni, input int nr, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k <= budget; k++) begin
      if (iss_q.size() >= ni && rsp_q.size() >= nr) begin
        ok = 1'b1;
        break;
      end
      @(negedge spy_clock); #1;
    end
  endtask

  task automatic do_reset;
    req = '0;
    spy_rst_n = 1'b0;
    repeat (2) @(negedge spy_clock);
    #1;
    spy_rst_n = 1'b1;
    iss_q.delete();
    rsp_q.delete();
    exp_q.delete();
  endtask

  task automatic push_exp(input int idx, input logic err);
    logic [AW-1:0] a;
    a = req_addr[idx*AW +: AW];
    exp_q.push_back('{SW'(idx), a, err ? '0 : pat(SW'(idx), a), err});
  endtask

  task automatic test_reset;
    #2 spy_rst_n = 1'b0;
    repeat (2) @(negedge spy_clock);
    #1;
    n_tests++;
    if (gnt !== '0) begin n_fail++; $display("FAIL reset_gnt got=%h want=0", gnt); end
    n_tests++;
    if ({sb_rd_en, rsp_vld} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes got=%b want=00", {sb_rd_en, rsp_vld}); end
    n_tests++;
    if ({sb_sel, sb_rd_addr} !== '0) begin n_fail++; $display("FAIL reset_sel_addr got=%h want=0", {sb_sel, sb_rd_addr}); end
    n_tests++;
    if ({rsp_data, rsp_err, busy} !== '0) begin n_fail++; $display("FAIL reset_rsp_busy got=%h want=0", {rsp_data, rsp_err, busy}); end
    spy_rst_n = 1'b1;
    repeat (2) @(negedge spy_clock);
    #1;
    n_tests++;
    if ({busy, 32'(iss_q.size())} !== 33'd0) begin n_fail++; $display("FAIL idle_after_reset busy=%b strobes=%0d want 0/0", busy, iss_q.size()); end
  endtask

  task automatic test_single;
    bit ok;
    int c0;
    resp_delay = 2;
    fixed_en   = 1'b1;
    fixed_word = 32'hDEADBEEF;
    req_addr[5*AW +: AW] = 12'h01A;
    exp_q.push_back('{5'd5, 12'h01A, 32'hDEADBEEF, 1'b0});
    c0 = cyc;
    req[5] = 1'b1;
    wait_for(1, 0, 10, ok);
    req = '0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL single_issue got=no strobe want=strobe within 10 cycles"); end
    else begin
      n_tests++;
      if (iss_q[0].cyc - c0 != 1) begin n_fail++; $display("FAIL single_req_latency got=%0d want=1", iss_q[0].cyc - c0); end
      @(negedge spy_clock); #1;
      n_tests++;
      if ({gnt, busy} !== {ONE << 5, 1'b1}) begin n_fail++; $display("FAIL single_gnt_hold got=%h want=%h", {gnt, busy}, {ONE << 5, 1'b1}); end
      wait_for(1, 1, 20, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL single_rsp got=no rsp_vld want=rsp_vld"); end
      else begin
        e = exp_q.pop_front(); it = iss_q.pop_front(); rt = rsp_q.pop_front();
        got  = {it.gnt, it.sel, it.addr, rt.err, rt.data};
        want = {ONE << e.sel, e.sel, e.addr, e.err, e.data};
        n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL single_txn got=%h want=%h", got, want); end
        n_tests++;
        if (rt.cyc - it.cyc != 3) begin n_fail++; $display("FAIL single_rsp_latency got=%0d want=3", rt.cyc - it.cyc); end
        @(negedge spy_clock); #1;
        n_tests++;
        if ({gnt, busy, rsp_vld} !== '0) begin n_fail++; $display("FAIL single_release got=%h want=0", {gnt, busy, rsp_vld}); end
      end
    end
    fixed_en = 1'b0;
    req_addr[5*AW +: AW] = addr_of(5);
  endtask

  task automatic test_round_robin;
    bit ok;
    int prev;
    do_reset();
    resp_delay = 1;
    push_exp(0, 1'b0); push_exp(3, 1'b0); push_exp(26, 1'b0); push_exp(0, 1'b0);
    req[0] = 1'b1; req[3] = 1'b1; req[26] = 1'b1;
    wait_for(4, 0, 40, ok);
    req = '0;
    if (ok) wait_for(4, 4, 40, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rr_progress got=%0d/%0d want=4/4", iss_q.size(), rsp_q.size()); end
    else begin
      prev = 0;
      for (int j = 0; j < 4; j++) begin
        e = exp_q.pop_front(); it = iss_q.pop_front(); rt = rsp_q.pop_front();
        got  = {it.gnt, it.sel, it.addr, rt.err, rt.data};
        want = {ONE << e.sel, e.sel, e.addr, e.err, e.data};
        n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL rr_txn%0d got=%h want=%h", j, got, want); end
        if (j > 0) begin
          n_tests++;
          if (it.cyc - prev != 4) begin n_fail++; $display("FAIL rr_spacing%0d got=%0d want=4", j, it.cyc - prev); end
        end
        prev = it.cyc;
      end
    end
  endtask

  task automatic test_wrap;
    bit ok;
    do_reset();
    resp_delay = 1;
    push_exp(25, 1'b0);
    req[25] = 1'b1;
    wait_for(1, 0, 10, ok);
    req = '0;
    if (ok) wait_for(1, 1, 20, ok);
    if (ok) begin
      e = exp_q.pop_front(); it = iss_q.pop_front(); rt = rsp_q.pop_front();
      got  = {it.gnt, it.sel, it.addr, rt.err, rt.data};
      want = {ONE << e.sel, e.sel, e.addr, e.err, e.data};
      n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL wrap_setup got=%h want=%h", got, want); end
      push_exp(26, 1'b0); push_exp(1, 1'b0);
      req[26] = 1'b1; req[1] = 1'b1;
      wait_for(2, 0, 20, ok);
      req = '0;
      if (ok) wait_for(2, 2, 20, ok);
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL wrap_progress got=%0d/%0d want=2/2", iss_q.size(), rsp_q.size()); end
    else begin
      for (int j = 0; j < 2; j++) begin
        e = exp_q.pop_front(); it = iss_q.pop_front(); rt = rsp_q.pop_front();
        got  = {it.gnt, it.sel, it.addr, rt.err, rt.data};
        want = {ONE << e.sel, e.sel, e.addr, e.err, e.data};
        n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL wrap_txn%0d got=%h want=%h", j, got, want); end
      end
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int dl [3];
    bit er [3];
    dl[0] = 7; er[0] = 1'b1;
    dl[1] = 4; er[1] = 1'b0;
    dl[2] = 5; er[2] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      resp_delay = dl[c];
      push_exp(9, er[c]);
      req[9] = 1'b1;
      wait_for(1, 0, 10, ok);
      req = '0;
      if (ok) wait_for(1, 1, 20, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL tmo%0d_progress got=%0d/%0d want=1/1", c, iss_q.size(), rsp_q.size()); end
      else begin
        e = exp_q.pop_front(); it = iss_q.pop_front(); rt = rsp_q.pop_front();
        got  = {it.gnt, it.sel, it.addr, rt.err, rt.data};
        want = {ONE << e.sel, e.sel, e.addr, e.err, e.data};
        n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL tmo%0d_txn got=%h want=%h", c, got, want); end
        n_tests++;
        if (rt.cyc - it.cyc != 5) begin n_fail++; $display("FAIL tmo%0d_latency got=%0d want=5", c, rt.cyc - it.cyc); end
        repeat (6) @(negedge spy_clock);
        #1;
        n_tests++;
        if ({32'(rsp_q.size()), busy, rsp_data} !== {32'd0, 1'b0, e.data}) begin
          n_fail++;
          $display("FAIL tmo%0d_late_vld got rsp=%0d busy=%b data=%h want rsp=0 busy=0 data=%h", c, rsp_q.size(), busy, rsp_data, e.data);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait;
    bit ok;
    resp_delay = 0;
    req[4] = 1'b1;
    wait_for(1, 0, 10, ok);
    req = '0;
    @(negedge spy_clock); #1;
    spy_rst_n = 1'b0;
    #1;
    rv = {gnt, sb_rd_en, sb_sel, sb_rd_addr, rsp_data, rsp_vld, rsp_err, busy};
    n_tests++;
    if (!ok || rv !== '0) begin n_fail++; $display("FAIL rst_mid_wait_outputs issued=%b got=%h want=0", ok, rv); end
    @(negedge spy_clock); #1;
    spy_rst_n = 1'b1;
    iss_q.delete();
    repeat (4) @(negedge spy_clock);
    #1;
    n_tests++;
    if ({32'(rsp_q.size()), busy} !== 33'd0) begin n_fail++; $display("FAIL rst_no_rsp got rsp=%0d busy=%b want 0/0", rsp_q.size(), busy); end
    resp_delay = 1;
    push_exp(2, 1'b0);
    req[2] = 1'b1; req[26] = 1'b1;
    wait_for(1, 0, 10, ok);
    req = '0;
    if (ok) wait_for(1, 1, 20, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rst_after_progress got=%0d/%0d want=1/1", iss_q.size(), rsp_q.size()); end
    else begin
      e = exp_q.pop_front(); it = iss_q.pop_front(); rt = rsp_q.pop_front();
      got  = {it.gnt, it.sel, it.addr, rt.err, rt.data};
      want = {ONE << e.sel, e.sel, e.addr, e.err, e.data};
      n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL rst_after_txn got=%h want=%h", got, want); end
    end
  endtask

  task automatic test_req_drop;
    bit ok;
    resp_delay = 2;
    push_exp(7, 1'b0);
    req[7] = 1'b1;
    wait_for(1, 0, 10, ok);
    @(negedge spy_clock); #1;
    req = '0;
    @(negedge spy_clock); #1;
    n_tests++;
    if (!ok || {gnt, busy} !== {ONE << 7, 1'b1}) begin n_fail++; $display("FAIL drop_gnt_hold got=%h want=%h", {gnt, busy}, {ONE << 7, 1'b1}); end
    if (ok) wait_for(1, 1, 20, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL drop_rsp got=%0d/%0d want=1/1", iss_q.size(), rsp_q.size()); end
    else begin
      e = exp_q.pop_front(); it = iss_q.pop_front(); rt = rsp_q.pop_front();
      got  = {it.gnt, it.sel, it.addr, rt.err, rt.data};
      want = {ONE << e.sel, e.sel, e.addr, e.err, e.data};
      n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL drop_txn got=%h want=%h", got, want); end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr_of(i);
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_reset_mid_wait();
    test_req_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=still running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fm_sb_rd_arb.md
FM_SB_RD_ARB -- requirements
Module: fm_sb_rd_arb

Interface
REQ-001 SHALL have parameter N_SB, default sb_mapped_n (27): number of spybuffers sharing the readback port.
REQ-002 SHALL have parameter AXI_DW, default axi_dw (32): readback data width.
REQ-003 SHALL have parameter ADDR_W, default 12: spybuffer word-address width.
REQ-004 SHALL have parameter TMO, default 255: readback timeout in cycles, 1..255.
REQ-005 SHALL have input spy_clock, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have input spy_rst_n, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have input req, N_SB bits: per-spybuffer read request, level.
REQ-008 SHALL have input req_addr, N_SB*ADDR_W bits: per-requester address; slice i belongs to req[i].
REQ-009 SHALL have output gnt, N_SB bits: one-hot grant, held for the whole transaction.
REQ-010 SHALL have output sb_rd_en, 1 bit: one-cycle read strobe to the shared spybuffer port.
REQ-011 SHALL have output sb_sel, clog2(N_SB) bits: index of the granted spybuffer.
REQ-012 SHALL have output sb_rd_addr, ADDR_W bits: registered copy of the granted address.
REQ-013 SHALL have input sb_rd_data, AXI_DW bits: muxed spybuffer read data.
REQ-014 SHALL have input sb_rd_vld, 1 bit: sb_rd_data is valid.
REQ-015 SHALL have output rsp_data, AXI_DW bits: returned word.
REQ-016 SHALL have output rsp_vld, 1 bit: one-cycle response strobe.
REQ-017 SHALL have output rsp_err, 1 bit: the response is a timeout.
REQ-018 SHALL have output busy, 1 bit: the FSM is not in IDLE.

Function
REQ-019 SHALL implement a four-state FSM with states IDLE, ISSUE, WAIT and RESP.
REQ-020 SHALL go IDLE->ISSUE when req is non-zero, selecting the first set bit at or above rr_ptr, wrapping from N_SB-1 to 0.
REQ-021 SHALL, on entering ISSUE, register gnt, sb_sel and sb_rd_addr, and assert sb_rd_en for exactly that one cycle; ISSUE->WAIT unconditionally.
REQ-022 SHALL, in WAIT, capture sb_rd_data when sb_rd_vld=1 and go to RESP with rsp_err=0.
REQ-023 SHALL, in WAIT, go to RESP with rsp_data=0 and rsp_err=1 when the wait counter reaches TMO and sb_rd_vld=0.
REQ-024 SHALL treat sb_rd_vld=1 in the timeout cycle as a successful read (rsp_err=0).
REQ-025 SHALL, in RESP, assert rsp_vld for one cycle, clear gnt, set rr_ptr to the granted index+1 (N_SB-1 wraps to 0), and return to IDLE.
REQ-026 SHALL ignore sb_rd_vld outside WAIT.
REQ-027 SHALL complete and report a transaction even if its req bit drops after the grant; req changes during ISSUE/WAIT/RESP SHALL NOT alter gnt.
REQ-028 SHALL give request-to-sb_rd_en latency of 1 cycle; sb_rd_vld to rsp_vld latency of 1 cycle; minimum back-to-back grant spacing of 4 cycles.
REQ-029 SHALL hold rsp_data, rsp_err and busy registered; the wait counter is 8 bits, cleared on entering WAIT, saturating.

Reset
REQ-030 SHALL, while spy_rst_n=0, force state IDLE, rr_ptr=0, gnt=0, sb_rd_en=0, sb_sel=0, sb_rd_addr=0, rsp_data=0, rsp_vld=0, rsp_err=0, busy=0 and the counter to 0.
REQ-031 SHALL abort any in-flight transaction on reset with no rsp_vld; the first request after release is served normally.

Structure
REQ-032 SHALL place the FSM state enum and TMO default in fm_sb_pkg; N_SB and AXI_DW SHALL derive from sb_mapped_n and axi_dw.
REQ-033 SHALL use one sub-module, fm_rr_pick: a combinational round-robin first-set-bit finder (req, rr_ptr -> index, found).

Verification
REQ-034 Single request: req[5]=1, addr 0x01A, vld 2 cycles after sb_rd_en with data 0xDEADBEEF -> gnt[5], sb_sel=5, sb_rd_addr=0x01A, rsp_data=0xDEADBEEF, rsp_err=0.
REQ-035 Round-robin fairness: req[0], req[3] and req[26] held with immediate vld -> grant order 0, 3, 26, 0.
REQ-036 Wrap: rr_ptr=26, req[26] and req[1] -> 26 then 1.
REQ-037 Timeout: TMO=4, no sb_rd_vld -> rsp_vld with rsp_err=1 and rsp_data=0 exactly 4 WAIT cycles after entering WAIT; a late vld is ignored.
REQ-038 Reset mid-WAIT: spy_rst_n low for 1 cycle -> all outputs 0 with no rsp_vld; a subsequent req[2] is served with rr_ptr=0.
REQ-039 Request drop: req[7] deasserted the cycle after its grant -> transaction completes and rsp_vld still fires.
